// File: rtl/mem_pkg.sv
// Shared constants for the CPU-to-RAM data memory bridge: RISC-V load/store
// funct3 codes, the RAM address region and the controller FSM encoding.
package mem_pkg;

    // Load/store width codes (funct3). Stores only use F3_B/F3_H/F3_W.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // addr[31:29] value that selects the RAM.
    localparam logic [2:0] RAM_REGION = 3'b000;

    // Controller FSM encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RD_DATA = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

endpackage

// File: rtl/load_extract.sv
// Combinational load formatter: picks the addressed byte/half/word out of a
// RAM word and sign- or zero-extends it to 32 bits.
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select by byte offset, then extend according to funct3.
    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Bridge between the CPU MEM stage and a word-addressed RAM with one cycle
// of registered read latency. Handles byte/half/word loads, read-modify-write
// for SB/SH, direct SW writes and reports misaligned/out-of-range accesses.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter logic [2:0]  REGION = RAM_REGION
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_done,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_in,
    output logic        ram_write_enable,
    input  logic [31:0] ram_data_out
);

    logic [1:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_din_q, ram_din_d;
    logic        ram_we_q, ram_we_d;

    logic        region_bad, range_bad, misalign, f3_bad, req_err;
    logic [31:0] load_word;
    logic [31:0] merged;

    load_extract u_load_extract (
        .word_i   (ram_data_out),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .data_o   (load_word)
    );

    // Classify the incoming request as legal or erroneous.
    always_comb begin
        region_bad = (req_addr[31:29] != REGION);
        range_bad  = |req_addr[31:ADDR_W+2];
        misalign   = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                     ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        if (req_write) begin
            f3_bad = !((req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W));
        end else begin
            f3_bad = !((req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                       (req_funct3 == F3_BU) || (req_funct3 == F3_HU));
        end
        req_err = region_bad | range_bad | misalign | f3_bad;
    end

    // Splice the store byte/half into the word just read from RAM.
    always_comb begin
        merged = ram_data_out;
        if (f3_q == F3_H) begin
            if (off_q[1]) begin
                merged[31:16] = wdata_q;
            end else begin
                merged[15:0] = wdata_q;
            end
        end else begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // FSM next-state and RAM/response register updates.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        f3_d       = f3_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = ram_we_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    err_d   = req_err;
                    if (req_err) begin
                        rdata_d = 32'h0;
                        state_d = ST_RESP;
                    end else if (req_write && (req_funct3 == F3_W)) begin
                        ram_addr_d = 32'(req_addr[ADDR_W+1:2]);
                        ram_din_d  = req_wdata;
                        ram_we_d   = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        ram_addr_d = 32'(req_addr[ADDR_W+1:2]);
                        ram_we_d   = 1'b0;
                        state_d    = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (write_q) begin
                    ram_din_d = merged;
                    ram_we_d  = 1'b1;
                end else begin
                    rdata_d = load_word;
                end
                state_d = ST_RESP;
            end
            default: begin
                ram_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any access and drops the write enable at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            ram_addr_q <= 32'h0;
            ram_din_q  <= 32'h0;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
        end
    end

    // Output decode.
    always_comb begin
        req_ready        = (state_q == ST_IDLE);
        resp_done        = (state_q == ST_RESP);
        resp_err         = resp_done & err_q;
        resp_rdata       = rdata_q;
        ram_address      = ram_addr_q;
        ram_data_in      = ram_din_q;
        ram_write_enable = ram_we_q;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl with a behavioural 1-cycle RAM.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_done;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_address;
    logic [31:0] ram_data_in;
    logic        ram_write_enable;
    logic [31:0] ram_data_out = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_done        (resp_done),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_data_out     (ram_data_out)
    );

    always #5 clk = ~clk;

    // Word-addressed RAM, read-before-write, registered read data.
    logic [31:0] mem [256] = '{default: 32'h0};
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (ram_write_enable) begin
            mem[ram_address[7:0]] <= ram_data_in;
            wr_cnt                <= wr_cnt + 1;
        end
        ram_data_out <= mem[ram_address[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of expected responses, popped when resp_done is seen.
    typedef struct packed {
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
    } sb_t;
    sb_t sb_q[$];

    always @(negedge clk) begin
        if (reset && resp_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(resp_done), 32'h0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.chk_rd) chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          wr;
        logic        cm;
        logic [31:0] m;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] rd, input logic err,
                                input int lat, input int wr, input logic cm,
                                input logic [31:0] m);
        vec_t v;
        v.w = w; v.f3 = f3; v.a = a; v.d = d; v.rd = rd; v.err = err;
        v.lat = lat; v.wr = wr; v.cm = cm; v.m = m;
        return v;
    endfunction

    // One complete access: drive, wait for done with a bound, check latency/writes/RAM.
    task automatic do_req(input vec_t v, input string name);
        int  cyc;
        bit  done;
        int  wr0;
        sb_t e;
        e.chk_rd = !v.w || v.err;
        e.rd     = v.rd;
        e.err    = v.err;
        sb_q.push_back(e);
        @(negedge clk);
        req_write  = v.w;
        req_funct3 = v.f3;
        req_addr   = v.a;
        req_wdata  = v.d;
        req_valid  = 1'b1;
        wr0        = wr_cnt;
        @(posedge clk);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            if (cyc == 1) chk({name, "_ready_busy"}, 32'(req_ready), 32'h0);
            if (resp_done) done = 1'b1;
        end
        if (!done) begin
            chk({name, "_timeout"}, 32'(cyc), 32'(v.lat));
            void'(sb_q.pop_front());
        end else begin
            chk({name, "_latency"}, 32'(cyc), 32'(v.lat));
            if (!v.err) chk({name, "_ram_address"}, ram_address, {22'h0, v.a[9:2]});
        end
        @(posedge clk);
        #1;
        chk({name, "_writes"}, 32'(wr_cnt - wr0), 32'(v.wr));
        if (v.cm) chk({name, "_mem"}, mem[v.a[9:2]], v.m);
    endtask

    localparam int NV = 25;
    vec_t vecs [NV];

    initial begin
        int wr0;
        int cyc;
        sb_t e;

        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        reset      = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_done", 32'(resp_done), 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_ram_addr", ram_address, 32'h0);
        chk("rst_ram_din", ram_data_in, 32'h0);
        chk("rst_ram_we", 32'(ram_write_enable), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        //            w     f3     addr          wdata         rdata        err lat wr cm mem
        vecs[0]  = mk(1'b1, F3_W,  32'h10,       32'hDEADBEEF, 32'h0,        0, 1, 1, 1, 32'hDEADBEEF);
        vecs[1]  = mk(1'b0, F3_W,  32'h10,       32'h0,        32'hDEADBEEF, 0, 3, 0, 0, 32'h0);
        vecs[2]  = mk(1'b1, F3_B,  32'h11,       32'hFFFFFF55, 32'h0,        0, 3, 1, 1, 32'hDEAD55EF);
        vecs[3]  = mk(1'b0, F3_B,  32'h11,       32'h0,        32'h00000055, 0, 3, 0, 0, 32'h0);
        vecs[4]  = mk(1'b0, F3_B,  32'h13,       32'h0,        32'hFFFFFFDE, 0, 3, 0, 0, 32'h0);
        vecs[5]  = mk(1'b0, F3_BU, 32'h13,       32'h0,        32'h000000DE, 0, 3, 0, 0, 32'h0);
        vecs[6]  = mk(1'b1, F3_H,  32'h12,       32'hABCD1234, 32'h0,        0, 3, 1, 1, 32'h123455EF);
        vecs[7]  = mk(1'b0, F3_H,  32'h12,       32'h0,        32'h00001234, 0, 3, 0, 0, 32'h0);
        vecs[8]  = mk(1'b1, F3_H,  32'h10,       32'h00008001, 32'h0,        0, 3, 1, 1, 32'h12348001);
        vecs[9]  = mk(1'b0, F3_H,  32'h10,       32'h0,        32'hFFFF8001, 0, 3, 0, 0, 32'h0);
        vecs[10] = mk(1'b0, F3_HU, 32'h10,       32'h0,        32'h00008001, 0, 3, 0, 0, 32'h0);
        vecs[11] = mk(1'b0, F3_W,  32'h10,       32'h0,        32'h12348001, 0, 3, 0, 0, 32'h0);
        vecs[12] = mk(1'b0, F3_W,  32'h11,       32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
        vecs[13] = mk(1'b1, F3_H,  32'h13,       32'h1111,     32'h0,        1, 1, 0, 1, 32'h12348001);
        vecs[14] = mk(1'b0, F3_W,  32'h20000000, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
        vecs[15] = mk(1'b0, F3_W,  32'h400,      32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
        vecs[16] = mk(1'b1, F3_W,  32'h3FC,      32'hA5A50F0F, 32'h0,        0, 1, 1, 1, 32'hA5A50F0F);
        vecs[17] = mk(1'b0, F3_W,  32'h3FC,      32'h0,        32'hA5A50F0F, 0, 3, 0, 0, 32'h0);
        vecs[18] = mk(1'b0, 3'b011, 32'h10,      32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
        vecs[19] = mk(1'b1, F3_BU, 32'h10,       32'hFFFFFFFF, 32'h0,        1, 1, 0, 1, 32'h12348001);
        vecs[20] = mk(1'b1, F3_W,  32'h12,       32'hFFFFFFFF, 32'h0,        1, 1, 0, 1, 32'h12348001);
        vecs[21] = mk(1'b0, F3_B,  32'h11,       32'h0,        32'hFFFFFF80, 0, 3, 0, 0, 32'h0);
        vecs[22] = mk(1'b0, F3_B,  32'h10,       32'h0,        32'h00000001, 0, 3, 0, 0, 32'h0);
        vecs[23] = mk(1'b1, F3_B,  32'h13,       32'h0000009A, 32'h0,        0, 3, 1, 1, 32'h9A348001);
        vecs[24] = mk(1'b0, F3_H,  32'h12,       32'h0,        32'hFFFF9A34, 0, 3, 0, 0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while a SB sits in RD_DATA: the write must never happen.
        do_req(mk(1'b1, F3_W, 32'h20, 32'h11223344, 32'h0, 0, 1, 1, 1, 32'h11223344), "pre_rst");
        @(negedge clk);
        req_write  = 1'b1;
        req_funct3 = F3_B;
        req_addr   = 32'h21;
        req_wdata  = 32'h99;
        req_valid  = 1'b1;
        wr0        = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_we", 32'(ram_write_enable), 32'h0);
        chk("rst_mid_ready", 32'(req_ready), 32'h1);
        chk("rst_mid_done", 32'(resp_done), 32'h0);
        chk("rst_mid_rdata", resp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rel_ready", 32'(req_ready), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_writes", 32'(wr_cnt - wr0), 32'h0);
        chk("rst_mid_mem", mem[8], 32'h11223344);

        // Back-to-back SW then LW with req_valid held high throughout.
        e.chk_rd = 1'b0; e.rd = 32'h0; e.err = 1'b0;
        sb_q.push_back(e);
        e.chk_rd = 1'b1; e.rd = 32'hCAFEF00D; e.err = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        wr0        = wr_cnt;
        req_write  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h30;
        req_wdata  = 32'hCAFEF00D;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_sw_done", 32'(resp_done), 32'h1);
        chk("b2b_sw_ready", 32'(req_ready), 32'h0);
        req_write = 1'b0;
        @(negedge clk);
        chk("b2b_idle_ready", 32'(req_ready), 32'h1);
        chk("b2b_idle_done", 32'(resp_done), 32'h0);
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (resp_done) break;
        end
        chk("b2b_lw_latency", 32'(cyc), 32'h3);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_after_done", 32'(resp_done), 32'h0);
        chk("b2b_after_ready", 32'(req_ready), 32'h1);
        chk("b2b_writes", 32'(wr_cnt - wr0), 32'h1);
        chk("b2b_mem", mem[12], 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
